// File: rtl/serial_rx_packet.sv
// serial_rx_packet: frames UART bytes into a fixed-length packet guarded by an
// XOR checksum byte, with an inter-byte timeout that abandons stalled packets.
module serial_rx_packet #(
  parameter int NUM_BYTES    = 44,
  parameter int TIMEOUT_CLKS = 5000000,
  parameter int TO_SIZE      = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data,
  input  logic                   new_data,
  output logic [NUM_BYTES*8-1:0] packet,
  output logic                   packet_valid,
  output logic                   chk_err,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_BYTES - 1);
  localparam logic [TO_SIZE-1:0] TO_MAX   = TO_SIZE'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_count;
  logic [TO_SIZE-1:0]       r_timer;
  logic [7:0]               r_xor;
  logic [NUM_BYTES*8-1:0]   r_shift;
  logic [NUM_BYTES*8-1:0]   r_packet;
  logic                     r_packet_valid;
  logic                     r_chk_err;
  logic                     r_timeout_err;

  state_t                   w_next_state;
  logic                     w_load_first;
  logic                     w_shift_en;
  logic                     w_timer_inc;
  logic                     w_pkt_good;
  logic                     w_pkt_bad;
  logic                     w_timeout;
  logic [NUM_BYTES*8-1:0]   w_shift_next;

  // Next-state decode; a strobe always beats a timeout landing on the same edge
  always_comb begin
    w_next_state = IDLE;
    w_load_first = 1'b0;
    w_shift_en   = 1'b0;
    w_timer_inc  = 1'b0;
    w_pkt_good   = 1'b0;
    w_pkt_bad    = 1'b0;
    w_timeout    = 1'b0;
    w_shift_next = r_shift << 8;
    w_shift_next[7:0] = data;
    case (r_state)
      IDLE: begin
        w_next_state = IDLE;
        if (new_data) begin
          w_load_first = 1'b1;
          w_next_state = (NUM_BYTES == 1) ? CHECK : COLLECT;
        end
      end
      COLLECT: begin
        w_next_state = COLLECT;
        if (new_data) begin
          w_shift_en = 1'b1;
          if (r_count == LAST_IDX) begin
            w_next_state = CHECK;
          end
        end else if (r_timer == TO_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      CHECK: begin
        w_next_state = CHECK;
        if (new_data) begin
          w_next_state = IDLE;
          if (data == r_xor) begin
            w_pkt_good = 1'b1;
          end else begin
            w_pkt_bad = 1'b1;
          end
        end else if (r_timer == TO_MAX) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register, datapath counters, shift buffer and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_timer        <= '0;
      r_xor          <= '0;
      r_shift        <= '0;
      r_packet       <= '0;
      r_packet_valid <= 1'b0;
      r_chk_err      <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_packet_valid <= w_pkt_good;
      r_chk_err      <= w_pkt_bad;
      r_timeout_err  <= w_timeout;
      if (w_load_first) begin
        r_shift <= w_shift_next;
        r_xor   <= data;
        r_count <= CNT_W'(1);
        r_timer <= '0;
      end else if (w_shift_en) begin
        r_shift <= w_shift_next;
        r_xor   <= r_xor ^ data;
        r_count <= r_count + CNT_W'(1);
        r_timer <= '0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + TO_SIZE'(1);
      end
      if (w_pkt_good) begin
        r_packet <= r_shift;
      end
      if (w_next_state == IDLE) begin
        r_count <= '0;
        r_timer <= '0;
        r_xor   <= '0;
      end
    end
  end

  assign packet       = r_packet;
  assign packet_valid = r_packet_valid;
  assign chk_err      = r_chk_err;
  assign timeout_err  = r_timeout_err;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_serial_rx_packet.sv
// Scoreboard bench for serial_rx_packet: a byte-stream reference model predicts
// each packet/checksum/timeout event and the edge it occurs on.
module tb_serial_rx_packet;

  localparam int NB = 4;
  localparam int TO = 100;
  localparam int TS = 8;

  localparam int KIND_GOOD    = 0;
  localparam int KIND_BAD     = 1;
  localparam int KIND_TIMEOUT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          new_data = 1'b0;
  logic [NB*8-1:0] packet;
  logic          packet_valid;
  logic          chk_err;
  logic          timeout_err;
  logic          busy;

  typedef struct {
    int          kind;
    logic [31:0] pkt;
    int          cyc;
  } ev_t;

  ev_t         sbq[$];
  logic [7:0]  partial[$];
  int          lastEdge = 0;
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  logic        rstAtEdge = 1'b0;
  logic [31:0] shownPacket = 32'h0;

  serial_rx_packet #(
    .NUM_BYTES(NB),
    .TIMEOUT_CLKS(TO),
    .TO_SIZE(TS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .new_data(new_data),
    .packet(packet),
    .packet_valid(packet_valid),
    .chk_err(chk_err),
    .timeout_err(timeout_err),
    .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter and a record of whether reset was sampled on the last edge
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    rstAtEdge  <= rst;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises an event pulse
  always @(negedge clk) begin
    int nPulse;
    int kindAct;
    ev_t e;
    if (rstAtEdge) begin
      shownPacket = 32'h0;
      checkOutput("resetPacket", 64'(packet), 64'h0);
      checkOutput("resetPulses", 64'({packet_valid, chk_err, timeout_err}), 64'h0);
      checkOutput("resetBusy", 64'(busy), 64'h0);
    end else begin
      nPulse = int'(packet_valid) + int'(chk_err) + int'(timeout_err);
      if (nPulse != 0) begin
        checkOutput("onePulse", 64'(nPulse), 64'd1);
        if (sbq.size() == 0) begin
          checkOutput("unexpectedPulse", 64'({packet_valid, chk_err, timeout_err}), 64'h0);
        end else begin
          e = sbq.pop_front();
          kindAct = packet_valid ? KIND_GOOD : (chk_err ? KIND_BAD : KIND_TIMEOUT);
          checkOutput("eventKind", 64'(kindAct), 64'(e.kind));
          checkOutput("eventCycle", 64'(cycleCount), 64'(e.cyc));
          if (e.kind == KIND_GOOD) shownPacket = e.pkt;
        end
      end
      checkOutput("packetHold", 64'(packet), 64'(shownPacket));
    end
  end

  // One stimulus slot: busy check against the model, then timeout prediction
  task automatic slotBegin(output int edgeIdx);
    @(negedge clk);
    if (!rstAtEdge && !rst) begin
      checkOutput("busy", 64'(busy), 64'(partial.size() != 0));
    end
    edgeIdx = cycleCount + 1;
  endtask

  task automatic idle(input int n);
    int edgeIdx;
    ev_t e;
    for (int i = 0; i < n; i++) begin
      slotBegin(edgeIdx);
      new_data = 1'b0;
      if (partial.size() != 0 && edgeIdx - lastEdge >= TO) begin
        e.kind = KIND_TIMEOUT;
        e.pkt  = 32'h0;
        e.cyc  = edgeIdx;
        sbq.push_back(e);
        partial.delete();
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int edgeIdx;
    ev_t e;
    logic [7:0]  x;
    logic [31:0] p;
    idle(gap);
    slotBegin(edgeIdx);
    new_data = 1'b1;
    data     = b;
    if (partial.size() < NB) begin
      partial.push_back(b);
    end else begin
      x = 8'h00;
      p = 32'h0;
      foreach (partial[i]) begin
        x = x ^ partial[i];
        p = (p << 8) | 32'(partial[i]);
      end
      e.kind = (x == b) ? KIND_GOOD : KIND_BAD;
      e.pkt  = p;
      e.cyc  = edgeIdx;
      sbq.push_back(e);
      partial.delete();
    end
    lastEdge = edgeIdx;
  endtask

  task automatic sendFrame(input logic [31:0] bytesIn, input logic [7:0] chk, input int gap);
    for (int i = 3; i >= 0; i--) applyStimulus(bytesIn[i*8 +: 8], gap);
    applyStimulus(chk, gap);
  endtask

  task automatic applyReset(input int n);
    int edgeIdx;
    for (int i = 0; i < n; i++) begin
      slotBegin(edgeIdx);
      rst      = 1'b1;
      new_data = (i == 0);
      data     = 8'($urandom);
    end
    @(negedge clk);
    rst      = 1'b0;
    new_data = 1'b0;
    partial.delete();
  endtask

  function automatic int randGap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 16) return int'($urandom_range(1, 5));
    if (r == 16) return TO - 1;
    if (r == 17) return TO;
    if (r == 18) return int'($urandom_range(TO + 1, TO + 30));
    return int'($urandom_range(2, 10));
  endfunction

  initial begin
    logic [31:0] fb;
    logic [7:0]  cx;
    rst = 1'b1;
    new_data = 1'b1;
    data = 8'h5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    new_data = 1'b0;
    idle(2);

    sendFrame(32'h11223344, 8'h44, 0);
    idle(3);
    sendFrame(32'h11223344, 8'h45, 0);
    idle(3);

    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    idle(TO);
    sendFrame(32'hAABBCCDD, 8'h00, 0);
    idle(2);

    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, TO - 1);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h04, 0);
    idle(2);

    applyStimulus(8'h77, 0);
    applyStimulus(8'h88, 0);
    idle(1);
    applyReset(2);
    sendFrame(32'h01020304, 8'h04, 0);
    idle(2);

    sendFrame(32'hDEADBEEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
    sendFrame(32'hCAFE0155, 8'hCA ^ 8'hFE ^ 8'h01 ^ 8'h55, 0);
    idle(3);

    for (int f = 0; f < 40; f++) begin
      fb = $urandom;
      cx = fb[31:24] ^ fb[23:16] ^ fb[15:8] ^ fb[7:0];
      if ($urandom_range(0, 3) == 0) cx = cx ^ (8'h01 << $urandom_range(0, 7));
      for (int i = 3; i >= 0; i--) applyStimulus(fb[i*8 +: 8], randGap());
      applyStimulus(cx, randGap());
    end

    idle(TO + 20);
    checkOutput("scoreboardDrained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
